// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and a counter-width helper.
package vga_pkg;

   localparam int H_VISIBLE_D = 640;
   localparam int H_FRONT_D   = 16;
   localparam int H_SYNC_D    = 96;
   localparam int H_BACK_D    = 48;
   localparam int V_VISIBLE_D = 480;
   localparam int V_FRONT_D   = 10;
   localparam int V_SYNC_D    = 2;
   localparam int V_BACK_D    = 33;

   localparam int H_TOTAL_D = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
   localparam int V_TOTAL_D = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

   // Smallest width that can represent max_value.
   function automatic int min_width(input int max_value);
      int w;
      w = 1;
      while ((1 << w) <= max_value) w++;
      return w;
   endfunction

   localparam int COORD_W_D = min_width(((H_TOTAL_D > V_TOTAL_D) ? H_TOTAL_D : V_TOTAL_D) - 1);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decodes of the value it will hold next.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_D,
   parameter int FRONT   = H_FRONT_D,
   parameter int SYNC    = H_SYNC_D,
   parameter int BACK    = H_BACK_D,
   parameter bit POL     = 1'b0,
   parameter int W       = COORD_W_D
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         advance,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         next_visible,
   output logic         next_sync
);

   localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] VIS_END  = W'(VISIBLE);
   localparam logic [W-1:0] SYNC_BEG = W'(VISIBLE + FRONT);
   localparam logic [W-1:0] SYNC_END = W'(VISIBLE + FRONT + SYNC);

   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;

   assign wrap = (count_reg == LAST);

   always_comb begin
      count_next = count_reg;
      if (advance) begin
         count_next = wrap ? '0 : count_reg + 1'b1;
      end
   end

   // Reset parks on the last position so the first advance lands on 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= LAST;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count        = count_reg;
   assign next_visible = (count_next < VIS_END);
   assign next_sync    = ((count_next >= SYNC_BEG) && (count_next < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator with pixel-clock enable.
// Optional scanline compare (line_cmp/line_match) when VGA_TIMING_LINE_CMP_EN is defined.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_D,
   parameter int H_FRONT   = H_FRONT_D,
   parameter int H_SYNC    = H_SYNC_D,
   parameter int H_BACK    = H_BACK_D,
   parameter int V_VISIBLE = V_VISIBLE_D,
   parameter int V_FRONT   = V_FRONT_D,
   parameter int V_SYNC    = V_SYNC_D,
   parameter int V_BACK    = V_BACK_D,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int COORD_W   = COORD_W_D
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
`ifdef VGA_TIMING_LINE_CMP_EN
   input  logic [COORD_W-1:0] line_cmp,
   output logic               line_match,
`endif
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COORD_W-1:0] x_pos,
   output logic [COORD_W-1:0] y_pos,
   output logic               line_start,
   output logic               frame_start
);

   logic h_wrap, h_next_vis, h_next_sync;
   logic v_wrap, v_next_vis, v_next_sync;
   logic v_advance;

   logic de_reg;
   logic hsync_reg;
   logic vsync_reg;
   logic line_start_reg;
   logic frame_start_reg;

   assign v_advance = pix_en & h_wrap;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .POL     (HSYNC_POL),
      .W       (COORD_W)
   ) h_axis (
      .clk          (clk),
      .rst          (rst),
      .advance      (pix_en),
      .count        (x_pos),
      .wrap         (h_wrap),
      .next_visible (h_next_vis),
      .next_sync    (h_next_sync)
   );

   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .POL     (VSYNC_POL),
      .W       (COORD_W)
   ) v_axis (
      .clk          (clk),
      .rst          (rst),
      .advance      (v_advance),
      .count        (y_pos),
      .wrap         (v_wrap),
      .next_visible (v_next_vis),
      .next_sync    (v_next_sync)
   );

   // Decodes come from next counter values, so they line up with x_pos/y_pos
   // and simply hold when pix_en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_reg          <= 1'b0;
         hsync_reg       <= ~HSYNC_POL;
         vsync_reg       <= ~VSYNC_POL;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         de_reg          <= h_next_vis & v_next_vis;
         hsync_reg       <= h_next_sync;
         vsync_reg       <= v_next_sync;
         line_start_reg  <= pix_en & h_wrap;
         frame_start_reg <= pix_en & h_wrap & v_wrap;
      end
   end

   assign de          = de_reg;
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

`ifdef VGA_TIMING_LINE_CMP_EN
   logic [COORD_W-1:0] y_new;
   logic               line_match_reg;

   // y_new never exceeds V_TOTAL-1, so out-of-range compare values cannot hit.
   assign y_new = v_wrap ? '0 : y_pos + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_match_reg <= 1'b0;
      end else begin
         line_match_reg <= pix_en & h_wrap & (y_new == line_cmp);
      end
   end

   assign line_match = line_match_reg;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 640x480 instance for line behaviour, a tiny-timing instance for whole frames.
module tb_vga_timing;

   logic       clk;
   logic       rst, pix_en;
   logic       hsync, vsync, de, line_start, frame_start;
   logic [9:0] x_pos, y_pos;

   logic       rst_s, pix_en_s;
   logic       hsync_s, vsync_s, de_s, line_start_s, frame_start_s;
   logic [3:0] x_s, y_s;

   logic [9:0] line_cmp;
   logic [3:0] line_cmp_s;
   logic       line_match, line_match_s;

   int n_tests = 0;
   int n_fail  = 0;
   int lm_cnt = 0, lm_s_cnt = 0, lm_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_timing dut (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
`ifdef VGA_TIMING_LINE_CMP_EN
      .line_cmp    (line_cmp),
      .line_match  (line_match),
`endif
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   // H total 15 (sync x=10..12, active high), V total 13 (sync y=8..9, active low)
   vga_timing #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
      .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .COORD_W (4)
   ) dut_s (
      .clk         (clk),
      .rst         (rst_s),
      .pix_en      (pix_en_s),
`ifdef VGA_TIMING_LINE_CMP_EN
      .line_cmp    (line_cmp_s),
      .line_match  (line_match_s),
`endif
      .hsync       (hsync_s),
      .vsync       (vsync_s),
      .de          (de_s),
      .x_pos       (x_s),
      .y_pos       (y_s),
      .line_start  (line_start_s),
      .frame_start (frame_start_s)
   );

`ifndef VGA_TIMING_LINE_CMP_EN
   assign line_match   = 1'b0;
   assign line_match_s = 1'b0;
`endif

   always @(negedge clk) begin
      if (line_match) lm_cnt++;
      if (line_match_s) lm_s_cnt++;
      if (line_match_s && !line_start_s) lm_bad++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int xm, ym, errs, hs_cnt, hs_first, hs_last, de_fall, ls_cnt, fs_cnt;
      int vs_cnt, vs_bad, vs_chg_bad, wrap_seen, prev_y;
      logic prev_vs, adv, e_de, e_hs, e_vs, e_ls, e_fs;

      rst = 1'b1; pix_en = 1'b0; rst_s = 1'b1; pix_en_s = 1'b0;
      line_cmp = 10'd600; line_cmp_s = 4'd3;
      tick(); tick();

      $display("[TB] reset state");
      check("rst_x", 32'(x_pos), 799);
      check("rst_y", 32'(y_pos), 524);
      check("rst_de", 32'(de), 0);
      check("rst_hs", 32'(hsync), 1);
      check("rst_vs", 32'(vsync), 1);
      check("rst_ls", 32'(line_start), 0);
      check("rst_fs", 32'(frame_start), 0);

      $display("[TB] single pix_en pulse");
      rst = 1'b0; pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      check("first_x", 32'(x_pos), 0);
      check("first_y", 32'(y_pos), 0);
      check("first_de", 32'(de), 1);
      check("first_fs", 32'(frame_start), 1);
      check("first_ls", 32'(line_start), 1);
      check("first_hs", 32'(hsync), 1);
      check("first_vs", 32'(vsync), 1);
      tick();
      check("hold_ls", 32'(line_start), 0);
      check("hold_fs", 32'(frame_start), 0);
      check("hold_x", 32'(x_pos), 0);
      check("hold_de", 32'(de), 1);

      $display("[TB] 800 continuous advances");
      xm = 0; ym = 0; errs = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
      de_fall = -1; ls_cnt = 0; fs_cnt = 0;
      pix_en = 1'b1;
      for (int i = 0; i < 800; i++) begin
         tick();
         xm = (xm == 799) ? 0 : xm + 1;
         if (xm == 0) ym++;
         if (int'(x_pos) != xm || int'(y_pos) != ym) errs++;
         if (!hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(x_pos);
            hs_last = int'(x_pos);
         end
         if (!de && de_fall < 0) de_fall = int'(x_pos);
         if (line_start) ls_cnt++;
         if (frame_start) fs_cnt++;
      end
      pix_en = 1'b0;
      check("line_pos_errs", 32'(errs), 0);
      check("hs_low_cnt", 32'(hs_cnt), 96);
      check("hs_first_x", 32'(hs_first), 656);
      check("hs_last_x", 32'(hs_last), 751);
      check("de_fall_x", 32'(de_fall), 640);
      check("line_end_x", 32'(x_pos), 0);
      check("line_end_y", 32'(y_pos), 1);
      check("line_end_ls", 32'(line_start), 1);
      check("line_ls_cnt", 32'(ls_cnt), 1);
      check("line_fs_cnt", 32'(fs_cnt), 0);

      $display("[TB] pix_en 1-in-4 across a line wrap");
      pix_en = 1'b1;
      repeat (795) tick();
      pix_en = 1'b0;
      check("pre_div_x", 32'(x_pos), 795);
      xm = 795; ym = 1; errs = 0; ls_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         adv = ((c % 4) == 0);
         pix_en = adv;
         tick();
         if (adv) begin
            xm = (xm == 799) ? 0 : xm + 1;
            if (xm == 0) ym++;
         end
         e_ls = adv && (xm == 0);
         if (int'(x_pos) != xm || int'(y_pos) != ym || line_start !== e_ls || frame_start !== 1'b0) errs++;
         if (line_start) ls_cnt++;
      end
      pix_en = 1'b0;
      check("div_errs", 32'(errs), 0);
      check("div_ls_cycles", 32'(ls_cnt), 1);
      check("div_x", 32'(x_pos), 5);
      check("div_y", 32'(y_pos), 2);

      $display("[TB] reset mid-line with pix_en high");
      pix_en = 1'b1;
      repeat (295) tick();
      check("pre_rst_x", 32'(x_pos), 300);
      check("pre_rst_de", 32'(de), 1);
      rst = 1'b1;
      tick();
      check("mid_rst_x", 32'(x_pos), 799);
      check("mid_rst_y", 32'(y_pos), 524);
      check("mid_rst_de", 32'(de), 0);
      check("mid_rst_hs", 32'(hsync), 1);
      check("mid_rst_vs", 32'(vsync), 1);
      check("mid_rst_ls", 32'(line_start), 0);
      check("mid_rst_fs", 32'(frame_start), 0);
      rst = 1'b0; pix_en = 1'b0;

      $display("[TB] small timing reset state");
      check("s_rst_x", 32'(x_s), 14);
      check("s_rst_y", 32'(y_s), 12);
      check("s_rst_hs", 32'(hsync_s), 0);
      check("s_rst_vs", 32'(vsync_s), 1);
      check("s_rst_de", 32'(de_s), 0);

      $display("[TB] small timing, two full frames plus one edge");
      rst_s = 1'b0; pix_en_s = 1'b1;
      xm = 14; ym = 12; errs = 0; vs_cnt = 0; vs_bad = 0; vs_chg_bad = 0;
      fs_cnt = 0; wrap_seen = 0; hs_cnt = 0; prev_y = 12; prev_vs = vsync_s;
      for (int i = 0; i < 391; i++) begin
         tick();
         xm = (xm == 14) ? 0 : xm + 1;
         if (xm == 0) ym = (ym == 12) ? 0 : ym + 1;
         e_de = (xm < 8) && (ym < 6);
         e_hs = (xm >= 10) && (xm < 13);
         e_vs = !((ym >= 8) && (ym < 10));
         e_ls = (xm == 0);
         e_fs = (xm == 0) && (ym == 0);
         if (int'(x_s) != xm || int'(y_s) != ym) errs++;
         if (de_s !== e_de || hsync_s !== e_hs || vsync_s !== e_vs) errs++;
         if (line_start_s !== e_ls || frame_start_s !== e_fs) errs++;
         if (!vsync_s) begin
            vs_cnt++;
            if (y_s != 4'd8 && y_s != 4'd9) vs_bad++;
         end
         if (vsync_s !== prev_vs && x_s != 4'd0) vs_chg_bad++;
         prev_vs = vsync_s;
         if (prev_y == 12 && y_s == 4'd0) wrap_seen++;
         prev_y = int'(y_s);
         if (frame_start_s) fs_cnt++;
         if (hsync_s) hs_cnt++;
      end
      pix_en_s = 1'b0;
      check("s_frame_errs", 32'(errs), 0);
      check("s_vs_low_cnt", 32'(vs_cnt), 60);
      check("s_vs_low_y", 32'(vs_bad), 0);
      check("s_vs_chg_x0", 32'(vs_chg_bad), 0);
      check("s_fs_cnt", 32'(fs_cnt), 3);
      check("s_y_wraps", 32'(wrap_seen), 3);
      check("s_hs_high_cnt", 32'(hs_cnt), 78);

`ifdef VGA_TIMING_LINE_CMP_EN
      $display("[TB] line compare");
      check("lm_out_of_range", 32'(lm_cnt), 0);
      check("lm_s_cnt", 32'(lm_s_cnt), 2);
      check("lm_s_with_ls", 32'(lm_bad), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
